// File: rtl/blend_frame_writer_if.sv
// Pixel-in / frame-buffer-write bundle for blend_frame_writer.
// master: the writer block; slave: pixel source and SRAM side.
interface blend_frame_writer_if #(
  parameter int ADDR_W = 19
);
  logic              val;
  logic [9:0]        sync_x;
  logic [9:0]        sync_y;
  logic [4:0]        dvi_r;
  logic [5:0]        dvi_g;
  logic [4:0]        dvi_b;
  logic [4:0]        ccd_r;
  logic [5:0]        ccd_g;
  logic [4:0]        ccd_b;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              wr_ack;
  logic              frame_done;
  logic              overflow;

  modport master (
    input  val, sync_x, sync_y,
    input  dvi_r, dvi_g, dvi_b,
    input  ccd_r, ccd_g, ccd_b,
    input  wr_ack,
    output wr_req, wr_addr, wr_data,
    output frame_done, overflow
  );

  modport slave (
    output val, sync_x, sync_y,
    output dvi_r, dvi_g, dvi_b,
    output ccd_r, ccd_g, ccd_b,
    output wr_ack,
    input  wr_req, wr_addr, wr_data,
    input  frame_done, overflow
  );
endinterface

// File: rtl/blend_frame_writer.sv
// Alpha blend / chroma key of DVI and CCD pixels, two-stage
// pipeline into a show-ahead FIFO draining to the SRAM port.
module blend_frame_writer #(
  parameter int          H_ACTIVE   = 640,
  parameter int          V_ACTIVE   = 480,
  parameter int          ALPHA      = 8,
  parameter bit          KEY_EN     = 1'b1,
  parameter logic [15:0] KEY_COLOR  = 16'h0000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          ADDR_W     = 19
) (
  input logic clk_25,
  input logic rst_n,
  blend_frame_writer_if.master bus
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   cnt_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } ent_t;

  localparam logic [9:0]  WD10 = 10'(ALPHA);
  localparam logic [9:0]  WC10 = 10'(16 - ALPHA);
  localparam logic [10:0] WD11 = 11'(ALPHA);
  localparam logic [10:0] WC11 = 11'(16 - ALPHA);
  localparam cnt_t        FULL = cnt_t'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  logic [4:0]  cr;
  logic [5:0]  cg;
  logic [4:0]  cb;
  logic [15:0] dvi;
  logic [15:0] ccd;
  logic        keyed;
  logic        in_range;
  ent_t        pix;

  always_comb begin
    dvi = {bus.dvi_r, bus.dvi_g, bus.dvi_b};
    ccd = {bus.ccd_r, bus.ccd_g, bus.ccd_b};
    cr = 5'((10'(bus.dvi_r) * WD10
           + 10'(bus.ccd_r) * WC10 + 10'd8) >> 4);
    cg = 6'((11'(bus.dvi_g) * WD11
           + 11'(bus.ccd_g) * WC11 + 11'd8) >> 4);
    cb = 5'((10'(bus.dvi_b) * WD10
           + 10'(bus.ccd_b) * WC10 + 10'd8) >> 4);
    keyed = KEY_EN && (ccd == KEY_COLOR);
    in_range = (32'(bus.sync_x) < 32'(H_ACTIVE))
            && (32'(bus.sync_y) < 32'(V_ACTIVE));
    pix.data = keyed ? dvi : {cr, cg, cb};
    pix.addr = ADDR_W'(32'(bus.sync_y) * 32'(H_ACTIVE)
                     + 32'(bus.sync_x));
  end

  logic s1_v;
  logic s2_v;
  ent_t s1;
  ent_t s2;
  ent_t mem [FIFO_DEPTH];
  ptr_t rptr;
  ptr_t wptr;
  cnt_t cnt;
  logic ovf;
  logic done;
  logic empty;
  logic full;
  logic pop;
  logic push;
  ent_t head;

  assign empty = (cnt == '0);
  assign full  = (cnt == FULL);
  assign pop   = !empty && bus.wr_ack;
  // A full FIFO still accepts when the head leaves this edge
  assign push  = s2_v && (!full || pop);
  assign head  = mem[rptr];

  always_ff @(posedge clk_25) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s1   <= '0;
      s2   <= '0;
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
      done <= 1'b0;
    end else begin
      s1_v <= bus.val && in_range;
      s1   <= pix;
      s2_v <= s1_v;
      s2   <= s1;
      if (push) wptr <= wptr + ptr_t'(1);
      if (pop)  rptr <= rptr + ptr_t'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + cnt_t'(1);
        2'b01:   cnt <= cnt - cnt_t'(1);
        default: cnt <= cnt;
      endcase
      if (s2_v && full && !pop) ovf <= 1'b1;
      done <= pop && (head.addr == LAST);
    end
  end

  always_ff @(posedge clk_25) begin
    if (push) mem[wptr] <= s2;
  end

  assign bus.wr_req     = !empty;
  assign bus.wr_addr    = empty ? '0 : head.addr;
  assign bus.wr_data    = empty ? '0 : head.data;
  assign bus.frame_done = done;
  assign bus.overflow   = ovf;

endmodule
